// File: rtl/mix_pkg.sv
`default_nettype none
// mix_pkg: state encoding, accumulator sizing and sample/frame helpers shared by the mixer.
package mix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_FETCH = 3'd2,
    ST_OUT   = 3'd3,
    ST_REC   = 3'd4,
    ST_FIN   = 3'd5
  } mix_state_t;

  function automatic int acc_width(input int smp_w, input int gain_w, input int n_track);
    return smp_w + gain_w + $clog2(n_track);
  endfunction

  function automatic logic signed [63:0] sat_smp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Frames are {L,R} with L in the upper half; helpers work on a 64-bit carrier.
  function automatic logic [63:0] frame_hi(input logic [63:0] word, input int w);
    return (word >> w) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] frame_lo(input logic [63:0] word, input int w);
    return word & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] frame_pack(input logic [63:0] hi, input logic [63:0] lo,
                                             input int w);
    return (hi << w) | (lo & ((64'd1 << w) - 64'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_chan_mac.sv
`default_nettype none
// mix_chan_mac: one channel of gain multiply, frame accumulation and output saturation.
module mix_chan_mac
  import mix_pkg::*;
#(
  parameter int SMP_W  = 16,
  parameter int GAIN_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic signed [SMP_W-1:0] smp,
  input  logic [GAIN_W-1:0]       gain,
  output logic signed [SMP_W-1:0] sat
);
  localparam int PW = SMP_W + GAIN_W + 1;

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic signed [ACC_W-1:0] acc;

  // Gain is unsigned; a zero top bit keeps the product signed; >>> floors toward -inf.
  always_comb begin
    prod    = PW'(smp) * PW'($signed({1'b0, gain}));
    shifted = prod >>> (GAIN_W - 1);
    sat     = SMP_W'(sat_smp(64'(acc), SMP_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(shifted);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mix_engine.sv
`default_nettype none
// mix_engine: N-track SDRAM stream mixer with per-track gain, saturating sum,
// zero-order-hold audio output and optional record-back as a length-prefixed track.
module mix_engine
  import mix_pkg::*;
#(
  parameter int N_TRACK = 8,
  parameter int ADDR_W  = 23,
  parameter int SMP_W   = 16,
  parameter int GAIN_W  = 8,
  parameter int REPEAT  = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic                              i_stop,
  input  logic [N_TRACK-1:0]                i_track_en,
  input  logic [N_TRACK-1:0][ADDR_W-1:0]    i_track_base,
  input  logic [N_TRACK-1:0][GAIN_W-1:0]    i_gain,
  input  logic                              i_rec_en,
  input  logic [ADDR_W-1:0]                 i_rec_base,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_mem_read,
  output logic                              o_mem_write,
  output logic [ADDR_W-1:0]                 o_mem_addr,
  output logic [2*SMP_W-1:0]                o_mem_wdata,
  input  logic [2*SMP_W-1:0]                i_mem_rdata,
  input  logic                              i_mem_done,
  output logic                              o_aud_valid,
  output logic [2*SMP_W-1:0]                o_aud_data,
  input  logic                              i_aud_ready
);
  localparam int DW    = 2 * SMP_W;
  localparam int ACC_W = acc_width(SMP_W, GAIN_W, N_TRACK);
  localparam int IDX_W = (N_TRACK > 1) ? $clog2(N_TRACK) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  mix_state_t                     state;
  logic [N_TRACK-1:0]             en;
  logic [N_TRACK-1:0]             live;
  logic [N_TRACK-1:0][ADDR_W-1:0] base;
  logic [N_TRACK-1:0][ADDR_W-1:0] ptr;
  logic [N_TRACK-1:0][ADDR_W-1:0] end_addr;
  logic                           rec_en;
  logic [ADDR_W-1:0]              rec_base;
  logic [ADDR_W-1:0]              rec_cnt;
  logic                           stop_pend;
  logic                           fresh;
  logic [IDX_W-1:0]               cur;
  logic [REP_W-1:0]               rep;
  logic [IDX_W:0]                 first_en;
  logic [IDX_W:0]                 next_en;
  logic [IDX_W:0]                 first_live;
  logic [IDX_W:0]                 next_live;
  logic signed [SMP_W-1:0]        smp_l;
  logic signed [SMP_W-1:0]        smp_r;
  logic signed [SMP_W-1:0]        sat_l;
  logic signed [SMP_W-1:0]        sat_r;
  logic                           fetch_done;
  logic                           mac_clr;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [IDX_W:0] find_from(input logic [N_TRACK-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int t = N_TRACK - 1; t >= 0; t--) begin
      if (m[t] && t >= from) r = {1'b1, IDX_W'(t)};
    end
    return r;
  endfunction

  // A track stays live until its read pointer reaches the end address.
  for (genvar t = 0; t < N_TRACK; t++) begin : g_live
    assign live[t] = en[t] && (ptr[t] != end_addr[t]);
  end

  always_comb begin
    first_en   = find_from(i_track_en, 0);
    next_en    = find_from(en, int'(cur) + 1);
    first_live = find_from(live, 0);
    next_live  = find_from(live, int'(cur) + 1);
  end

  assign smp_l      = SMP_W'(frame_hi(64'(i_mem_rdata), SMP_W));
  assign smp_r      = SMP_W'(frame_lo(64'(i_mem_rdata), SMP_W));
  assign fetch_done = (state == ST_FETCH) && !fresh && o_mem_read && i_mem_done;
  assign mac_clr    = (state == ST_FETCH) && fresh;

  mix_chan_mac #(.SMP_W(SMP_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_l (
    .clk(i_clk), .rst(i_rst), .clr(mac_clr), .acc_en(fetch_done),
    .smp(smp_l), .gain(i_gain[cur]), .sat(sat_l)
  );

  mix_chan_mac #(.SMP_W(SMP_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_r (
    .clk(i_clk), .rst(i_rst), .clr(mac_clr), .acc_en(fetch_done),
    .smp(smp_r), .gain(i_gain[cur]), .sat(sat_r)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      en          <= '0;
      base        <= '0;
      ptr         <= '0;
      end_addr    <= '0;
      rec_en      <= 1'b0;
      rec_base    <= '0;
      rec_cnt     <= '0;
      stop_pend   <= 1'b0;
      fresh       <= 1'b0;
      cur         <= '0;
      rep         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_aud_valid <= 1'b0;
      o_aud_data  <= '0;
    end else begin
      o_done <= 1'b0;
      if (o_busy && i_stop) stop_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            en        <= i_track_en;
            base      <= i_track_base;
            rec_en    <= i_rec_en;
            rec_base  <= i_rec_base;
            ptr       <= '0;
            end_addr  <= '0;
            rec_cnt   <= '0;
            stop_pend <= 1'b0;
            cur       <= first_en[IDX_W-1:0];
            if (first_en[IDX_W]) begin
              o_busy <= 1'b1;
              state  <= ST_LEN;
            end else begin
              o_done <= 1'b1;
            end
          end
        end

        ST_LEN: begin
          if (!o_mem_read) begin
            o_mem_read <= 1'b1;
            o_mem_addr <= base[cur];
          end else if (i_mem_done) begin
            o_mem_read    <= 1'b0;
            ptr[cur]      <= base[cur] + ADDR_ONE;
            end_addr[cur] <= base[cur] + ADDR_ONE + i_mem_rdata[ADDR_W-1:0];
            if (next_en[IDX_W]) begin
              cur <= next_en[IDX_W-1:0];
            end else begin
              state <= ST_FETCH;
              fresh <= 1'b1;
            end
          end
        end

        // The fresh cycle is the frame boundary: decide to finish or clear and restart.
        ST_FETCH: begin
          if (fresh) begin
            fresh <= 1'b0;
            if (stop_pend || !first_live[IDX_W]) state <= ST_FIN;
            else cur <= first_live[IDX_W-1:0];
          end else if (!o_mem_read) begin
            o_mem_read <= 1'b1;
            o_mem_addr <= ptr[cur];
          end else if (i_mem_done) begin
            o_mem_read <= 1'b0;
            ptr[cur]   <= ptr[cur] + ADDR_ONE;
            if (next_live[IDX_W]) cur <= next_live[IDX_W-1:0];
            else state <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (!o_aud_valid) begin
            o_aud_valid <= 1'b1;
            o_aud_data  <= DW'(frame_pack(64'(sat_l), 64'(sat_r), SMP_W));
            rep         <= '0;
          end else if (i_aud_ready) begin
            if (int'(rep) == REPEAT - 1) begin
              o_aud_valid <= 1'b0;
              if (rec_en) begin
                state <= ST_REC;
              end else begin
                state <= ST_FETCH;
                fresh <= 1'b1;
              end
            end else begin
              rep <= rep + REP_W'(1);
            end
          end
        end

        ST_REC: begin
          if (!o_mem_write) begin
            o_mem_write <= 1'b1;
            o_mem_addr  <= rec_base + ADDR_ONE + rec_cnt;
            o_mem_wdata <= o_aud_data;
          end else if (i_mem_done) begin
            o_mem_write <= 1'b0;
            rec_cnt     <= rec_cnt + ADDR_ONE;
            state       <= ST_FETCH;
            fresh       <= 1'b1;
          end
        end

        ST_FIN: begin
          if (rec_en && !o_mem_write) begin
            o_mem_write <= 1'b1;
            o_mem_addr  <= rec_base;
            o_mem_wdata <= DW'(rec_cnt);
          end else if (!rec_en || i_mem_done) begin
            o_mem_write <= 1'b0;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
